// File: rtl/parking_entry_console.sv
// Board-side console for the car park controller: debounces the gate sensors and
// collects a two-digit keypad password after each car arrival.
module parking_entry_console #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       key_valid,
    input  logic [1:0] key_code,
    input  logic       key_clear,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pwd_valid,
    output logic       timeout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGIT1 = 2'd1,
        DIGIT2 = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

    // Channel 0 is the entrance sensor, channel 1 the exit sensor.
    logic [1:0] raw_in;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] db_out;
    logic [7:0] db_cnt [2];
    logic       entrance_q;
    logic       entry_rise;

    assign raw_in = {raw_exit, raw_entrance};

    // The output flips on the edge where the stable run reaches DEBOUNCE_CYCLES,
    // giving a total raw-to-output latency of 2 + DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 2'b00;
            sync2      <= 2'b00;
            db_out     <= 2'b00;
            entrance_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= 8'd0;
            end
        end else begin
            sync1      <= raw_in;
            sync2      <= sync1;
            entrance_q <= db_out[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db_out[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_out[i] <= sync2[i];
                        db_cnt[i] <= 8'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= 8'd0;
                end
            end
        end
    end

    assign entry_rise      = db_out[0] & ~entrance_q;
    assign sensor_entrance = db_out[0];
    assign sensor_exit     = db_out[1];

    // Keypad strobes carry no ready: key_valid/key_clear are one-cycle strobes taken
    // on the edge where they are high, and only DIGIT1/DIGIT2 consume them.
    state_t      state_q, state_n;
    logic [1:0]  pwd1_q, pwd1_n;
    logic [1:0]  pwd2_q, pwd2_n;
    logic        valid_q, valid_n;
    logic        tmo_q, tmo_n;
    logic [15:0] tcnt_q, tcnt_n;
    logic [7:0]  hcnt_q, hcnt_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pwd1_q  <= 2'd0;
            pwd2_q  <= 2'd0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            tcnt_q  <= 16'd0;
            hcnt_q  <= 8'd0;
        end else begin
            state_q <= state_n;
            pwd1_q  <= pwd1_n;
            pwd2_q  <= pwd2_n;
            valid_q <= valid_n;
            tmo_q   <= tmo_n;
            tcnt_q  <= tcnt_n;
            hcnt_q  <= hcnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pwd1_n  = pwd1_q;
        pwd2_n  = pwd2_q;
        valid_n = valid_q;
        tmo_n   = 1'b0;
        tcnt_n  = tcnt_q;
        hcnt_n  = hcnt_q;
        case (state_q)
            IDLE: begin
                if (entry_rise) begin
                    state_n = DIGIT1;
                    pwd1_n  = 2'd0;
                    pwd2_n  = 2'd0;
                    tcnt_n  = 16'd0;
                end
            end
            DIGIT1, DIGIT2: begin
                if (key_clear) begin
                    state_n = DIGIT1;
                    pwd1_n  = 2'd0;
                    pwd2_n  = 2'd0;
                    tcnt_n  = 16'd0;
                end else if (key_valid) begin
                    tcnt_n = 16'd0;
                    if (state_q == DIGIT1) begin
                        pwd1_n  = key_code;
                        state_n = DIGIT2;
                    end else begin
                        pwd2_n  = key_code;
                        state_n = HOLD;
                        valid_n = 1'b1;
                        hcnt_n  = 8'd0;
                    end
                end else if (tcnt_q == TMO_LAST) begin
                    state_n = IDLE;
                    pwd1_n  = 2'd0;
                    pwd2_n  = 2'd0;
                    tmo_n   = 1'b1;
                    tcnt_n  = 16'd0;
                end else begin
                    tcnt_n = tcnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (hcnt_q == HOLD_LAST) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    hcnt_n  = 8'd0;
                end else begin
                    hcnt_n = hcnt_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign password_1 = pwd1_q;
    assign password_2 = pwd2_q;
    assign pwd_valid  = valid_q;
    assign timeout    = tmo_q;
    assign state      = state_q;

endmodule

// File: tb/tb_parking_entry_console.sv
// Directed and randomized checks of parking_entry_console against a cycle-level
// behavioural model built from the sensor and password session rules.
module tb_parking_entry_console;

    localparam int DB  = 4;
    localparam int TMO = 64;
    localparam int HLD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_entrance;
    logic       raw_exit;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_clear;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pwd_valid;
    logic       timeout;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    parking_entry_console #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TMO),
        .HOLD_CYCLES    (HLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .raw_entrance   (raw_entrance),
        .raw_exit       (raw_exit),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_clear      (key_clear),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .password_1     (password_1),
        .password_2     (password_2),
        .pwd_valid      (pwd_valid),
        .timeout        (timeout),
        .state          (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: raw history per sensor, stable-run lengths, and a session
    // phase with remaining idle/hold budgets.
    logic hist_e[$];
    logic hist_x[$];
    logic m_db[2];
    int   m_run[2];
    logic m_ent_prev;
    int   m_state;
    logic [1:0] m_p1, m_p2;
    logic m_valid, m_tmo;
    int   idle_left, hold_left;

    task automatic model_reset();
        hist_e.delete();
        hist_x.delete();
        for (int c = 0; c < 2; c++) begin
            m_db[c]  = 1'b0;
            m_run[c] = 0;
        end
        m_ent_prev = 1'b0;
        m_state    = 0;
        m_p1       = 2'd0;
        m_p2       = 2'd0;
        m_valid    = 1'b0;
        m_tmo      = 1'b0;
        idle_left  = 0;
        hold_left  = 0;
    endtask

    task automatic model_edge();
        logic rise;
        logic del[2];
        rise  = m_db[0] && !m_ent_prev;
        m_tmo = 1'b0;
        case (m_state)
            0: if (rise) begin
                m_state = 1; m_p1 = 2'd0; m_p2 = 2'd0; idle_left = TMO;
            end
            1, 2: begin
                if (key_clear) begin
                    m_state = 1; m_p1 = 2'd0; m_p2 = 2'd0; idle_left = TMO;
                end else if (key_valid) begin
                    idle_left = TMO;
                    if (m_state == 1) begin
                        m_p1 = key_code; m_state = 2;
                    end else begin
                        m_p2 = key_code; m_state = 3; m_valid = 1'b1; hold_left = HLD;
                    end
                end else begin
                    idle_left--;
                    if (idle_left == 0) begin
                        m_state = 0; m_p1 = 2'd0; m_p2 = 2'd0; m_tmo = 1'b1;
                    end
                end
            end
            default: begin
                hold_left--;
                if (hold_left == 0) begin
                    m_state = 0; m_valid = 1'b0;
                end
            end
        endcase
        m_ent_prev = m_db[0];
        hist_e.push_back(raw_entrance);
        hist_x.push_back(raw_exit);
        if (hist_e.size() > 3) hist_e.delete(0);
        if (hist_x.size() > 3) hist_x.delete(0);
        del[0] = (hist_e.size() == 3) ? hist_e[0] : 1'b0;
        del[1] = (hist_x.size() == 3) ? hist_x[0] : 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (del[c] !== m_db[c]) begin
                m_run[c]++;
                if (m_run[c] == DB) begin
                    m_db[c]  = del[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("sensor_entrance", 32'(sensor_entrance), 32'(m_db[0]));
        check("sensor_exit", 32'(sensor_exit), 32'(m_db[1]));
        check("password_1", 32'(password_1), 32'(m_p1));
        check("password_2", 32'(password_2), 32'(m_p2));
        check("pwd_valid", 32'(pwd_valid), 32'(m_valid));
        check("timeout", 32'(timeout), 32'(m_tmo));
        check("state", 32'(state), 32'(m_state));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input logic [1:0] code);
        key_valid = 1'b1;
        key_code  = code;
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
        int n = 0;
        while (state !== target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(state), 32'(target));
    endtask

    task automatic rearm();
        raw_entrance = 1'b0;
        repeat (8) step();
        raw_entrance = 1'b1;
        wait_state(2'd1, 20, "rearm_digit1");
    endtask

    initial begin
        int lat;
        int vcnt;
        int tcount;
        logic seen;
        reset = 1'b1; raw_entrance = 1'b0; raw_exit = 1'b0;
        key_valid = 1'b0; key_code = 2'd0; key_clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_sensors", 32'({sensor_entrance, sensor_exit}), 32'd0);
        check("reset_pwd", 32'({password_1, password_2}), 32'd0);
        check("reset_flags", 32'({pwd_valid, timeout}), 32'd0);
        reset = 1'b0;

        // Short exit glitch must be filtered.
        seen = 1'b0;
        raw_exit = 1'b1;
        repeat (3) begin step(); seen = seen | sensor_exit; end
        raw_exit = 1'b0;
        repeat (10) begin step(); seen = seen | sensor_exit; end
        check("exit_glitch", 32'(seen), 32'd0);

        lat = 0;
        raw_entrance = 1'b1;
        while (sensor_entrance !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("debounce_latency", 32'(lat), 32'd6);
        step();
        check("entry_to_digit1", 32'(state), 32'd1);

        press(2'd1);
        check("digit1_state", 32'(state), 32'd2);
        check("digit1_value", 32'(password_1), 32'd1);
        press(2'd2);
        check("digit2_state", 32'(state), 32'd3);
        check("digit2_value", 32'(password_2), 32'd2);
        check("valid_rise", 32'(pwd_valid), 32'd1);
        vcnt = 1;
        key_valid = 1'b1; key_code = 2'd3;
        step();
        key_valid = 1'b0;
        if (pwd_valid) vcnt++;
        while (pwd_valid === 1'b1 && vcnt < 20) begin
            step();
            if (pwd_valid) vcnt++;
        end
        check("hold_length", 32'(vcnt), 32'd8);
        check("hold_to_idle", 32'(state), 32'd0);
        check("hold_kept_pwd", 32'({password_1, password_2}), 32'b0110);
        press(2'd3);
        check("idle_key_state", 32'(state), 32'd0);
        check("idle_key_pwd", 32'({password_1, password_2}), 32'b0110);

        // Second entrance rise while in DIGIT1 must not restart anything.
        rearm();
        raw_entrance = 1'b0;
        repeat (8) step();
        raw_entrance = 1'b1;
        repeat (8) step();
        check("second_rise_ignored", 32'(state), 32'd1);

        press(2'd1);
        key_clear = 1'b1; key_valid = 1'b1; key_code = 2'd3;
        step();
        key_clear = 1'b0; key_valid = 1'b0;
        check("clear_state", 32'(state), 32'd1);
        check("clear_pwd", 32'({password_1, password_2}), 32'd0);
        press(2'd3);
        press(2'd0);
        check("after_clear_pwd", 32'({password_1, password_2}), 32'b1100);
        check("after_clear_state", 32'(state), 32'd3);
        repeat (10) step();

        rearm();
        press(2'd2);
        tcount = 0;
        repeat (63) begin step(); if (timeout) tcount++; end
        check("pre_timeout_state", 32'(state), 32'd2);
        check("pre_timeout_pulse", 32'(tcount), 32'd0);
        step();
        check("timeout_pulse", 32'(timeout), 32'd1);
        check("timeout_state", 32'(state), 32'd0);
        check("timeout_pwd", 32'({password_1, password_2}), 32'd0);
        check("timeout_valid", 32'(pwd_valid), 32'd0);
        step();
        check("timeout_one_cycle", 32'(timeout), 32'd0);

        rearm();
        press(2'd1);
        check("pre_reset_state", 32'(state), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_pwd", 32'({password_1, password_2}), 32'd0);
        check("async_reset_flags", 32'({pwd_valid, timeout}), 32'd0);
        check("async_reset_sensors", 32'({sensor_entrance, sensor_exit}), 32'd0);
        model_reset();
        step();
        step();
        reset = 1'b0;
        repeat (20) step();

        repeat (3000) begin
            if ($urandom_range(0, 11) == 0) raw_entrance = ~raw_entrance;
            if ($urandom_range(0, 11) == 0) raw_exit = ~raw_exit;
            key_valid = ($urandom_range(0, 29) == 0);
            key_code  = 2'($urandom_range(0, 3));
            key_clear = ($urandom_range(0, 149) == 0);
            step();
        end
        key_valid = 1'b0; key_clear = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
